mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified system memory (4096 x 32-bit words; text from word 0, data from word 2048) between two requesters: the CPU instruction-fetch port and the load/store data port.
- Serialises their accesses, converts byte addresses to word indices, enforces the memory read latency, and returns one-cycle completion pulses.
- Prevents fetch starvation under back-to-back data traffic.
- Sits between the CPU core and the system memory; the CPU uses the done pulses as its stall release.

Parameters:
- AW, 12, memory word-address width (4096 words).
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..4).
- MAX_STREAK, 4, maximum consecutive data grants while a fetch is pending.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch byte address; stable while if_req.
- if_done  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  32  fetched word; valid with if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse; data access complete.
- d_rdata  out  32  load data; valid with d_done.
- d_err  out  1  misaligned address; valid with d_done.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State returns to IDLE; streak counter clears.
  - All outputs are registered and reset to 0.
  - Any in-flight access is abandoned and no done pulse is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - At each edge, sample if_req and d_req.
  - If neither is asserted, stay in IDLE.
  - Otherwise latch the owner, word index addr[AW+1:2], we and wdata, then go to ISSUE.
  - Fetch is always a read.
- Arbitration:
  - Data wins unless if_req is asserted and streak == MAX_STREAK; in that case fetch wins.
  - streak increments on each data grant made while if_req is asserted, saturating at MAX_STREAK.
  - streak clears on any fetch grant and whenever if_req is low at a grant.
- Misalignment: a data request with d_addr[1:0] != 0 bypasses memory. IDLE goes directly to DONE with d_err=1, d_rdata=0 and no mem_en. Fetch alignment is not checked; bits [1:0] are ignored.
- Address bits above AW+1 are ignored, so addresses wrap modulo 4096 words.
- ISSUE:
  - mem_en=1 for exactly one cycle, with mem_addr, mem_we and mem_wdata driven from the latched values.
  - A store goes to DONE.
  - A load goes to WAIT.
- WAIT: counts MEM_LAT cycles, then captures mem_rdata into the owner's rdata register and goes to DONE.
- DONE:
  - The owner's done pulse is high for exactly one cycle.
  - The non-owner's done and rdata are 0.
  - Next state is IDLE.
- Latency, measured from the edge that samples the request in IDLE:
  - Store done at +2 cycles.
  - Load or fetch done at +2+MEM_LAT cycles.
  - Misaligned done at +1 cycle.
- Back-to-back accesses:
  - After a done pulse the requester may deassert req or present a new request.
  - Because DONE always returns to IDLE, a req still high in the DONE cycle is treated as a new request.
- Simultaneous requests follow the arbitration rule above. The loser keeps req high and waits with no timeout.
- mem_wdata is 0 for reads. mem_we=1 only when mem_en=1.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds output ports if_grants[31:0], d_grants[31:0] and conflict_cycles[31:0]. All three clear on reset and wrap at 2^32.
  - if_grants and d_grants increment on each grant.
  - conflict_cycles increments on each cycle in which both requests are asserted and neither requester is the current owner.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State encoding typedef (IDLE/ISSUE/WAIT/DONE).
  - Owner enum (OWN_IF/OWN_D).
  - Constants: WORD_BYTES=4, DATA_BASE_WORD=2048.
- One sub-module: arb_pick, the combinational grant decision plus the streak counter register.

Test Plan:
- Fetch only: if_req with if_addr=0x8, mem word 2 = 0x2008FFFF, MEM_LAT=1 -> mem_en one cycle with mem_addr=2; if_done pulses 3 cycles after sampling with if_rdata=0x2008FFFF.
- Store then load:
  - Store d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=2048, d_done at +2.
  - Load d_addr=0x2000 -> d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF; if_done never missing for more than 4 data grants.
- Misaligned: d_addr=0x2002 -> d_done after 1 cycle with d_err=1, no mem_en.
- Reset mid-operation: reset_n low during WAIT -> next cycle all outputs 0, no done pulse; a fresh request afterwards completes normally.
- MEM_LAT=3 with MEM_ARB_STATS_EN defined: 5 fetches -> each done at +5; if_grants=5, d_grants=0, conflict_cycles=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int WORD_BYTES     = 4;
    localparam int DATA_BASE_WORD = 2048;

endpackage

// File: rtl/arb_pick.sv
// Grant decision between fetch and data, plus the data-streak counter.
// Combinational pick; streak register updates only on a grant.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  logic   i_grant_en,
    output owner_t o_owner
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_if_wins;

    // Data has priority until it has won MAX_STREAK times in a row over a waiting fetch.
    assign w_if_wins = i_if_req && (!i_d_req || (r_streak == SW'(MAX_STREAK)));
    assign o_owner   = w_if_wins ? OWN_IF : OWN_D;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_streak <= '0;
        end else if (i_grant_en) begin
            if (w_if_wins || !i_if_req) begin
                r_streak <= '0;
            end else if (r_streak != SW'(MAX_STREAK)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store onto one memory port; all outputs registered.
// Done at +2 (store), +2+MEM_LAT (load/fetch), +1 (misaligned) from the sampling edge.
// Loser holds req until its done; MEM_ARB_STATS_EN adds grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 12,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   if_grants,
    output logic [31:0]   d_grants,
    output logic [31:0]   conflict_cycles
`endif
);
    localparam int OFS = $clog2(WORD_BYTES);
    localparam int CW  = $clog2(MEM_LAT) + 1;

    state_t        r_state, w_state_nxt;
    owner_t        r_owner, w_owner_nxt, w_grant_owner;
    logic          r_we;
    logic [CW-1:0] r_lat_cnt;
    logic          w_grant_en, w_d_misal, w_unused_bits;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic          w_cap, w_mem_en_nxt, w_mem_we_nxt;
    logic          w_if_done_nxt, w_d_done_nxt, w_d_err_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [31:0]   w_mem_wdata_nxt, w_if_rdata_nxt, w_d_rdata_nxt;

    assign w_grant_en    = (r_state == IDLE) && (if_req || d_req);
    assign w_d_misal     = d_addr[OFS-1:0] != '0;
    assign w_unused_bits = &{1'b0, if_addr[31:AW+OFS], if_addr[OFS-1:0], d_addr[31:AW+OFS]};

    arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_if_req   (if_req),
        .i_d_req    (d_req),
        .i_grant_en (w_grant_en),
        .o_owner    (w_grant_owner)
    );

    // Upper address bits are dropped, so accesses wrap modulo the memory size.
    always_comb begin
        w_sel_addr  = if_addr[AW+OFS-1:OFS];
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        if (w_grant_owner == OWN_D) begin
            w_sel_addr  = d_addr[AW+OFS-1:OFS];
            w_sel_we    = d_we;
            w_sel_wdata = d_we ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_en) w_state_nxt = (w_grant_owner == OWN_D && w_d_misal) ? DONE : ISSUE;
            ISSUE:   w_state_nxt = r_we ? DONE : WAIT;
            WAIT:    if (r_lat_cnt == CW'(MEM_LAT - 1)) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            if (w_grant_en) begin
                r_owner <= w_grant_owner;
                r_we    <= w_sel_we;
            end
            r_lat_cnt <= (r_state == WAIT) ? r_lat_cnt + 1'b1 : '0;
        end
    end

    // Outputs are computed one state ahead so the registered copies line up with the state.
    assign w_owner_nxt = (r_state == IDLE) ? w_grant_owner : r_owner;

    always_comb begin
        w_cap           = (r_state == WAIT) && (w_state_nxt == DONE);
        w_mem_en_nxt    = (w_state_nxt == ISSUE);
        w_mem_we_nxt    = w_mem_en_nxt && w_sel_we;
        w_mem_addr_nxt  = w_mem_en_nxt ? w_sel_addr : '0;
        w_mem_wdata_nxt = w_mem_en_nxt ? w_sel_wdata : '0;
        w_if_done_nxt   = (w_state_nxt == DONE) && (w_owner_nxt == OWN_IF);
        w_d_done_nxt    = (w_state_nxt == DONE) && (w_owner_nxt == OWN_D);
        w_d_err_nxt     = (r_state == IDLE) && (w_state_nxt == DONE);
        w_if_rdata_nxt  = (w_cap && r_owner == OWN_IF) ? mem_rdata : '0;
        w_d_rdata_nxt   = (w_cap && r_owner == OWN_D) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            mem_en    <= w_mem_en_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            if_done   <= w_if_done_nxt;
            if_rdata  <= w_if_rdata_nxt;
            d_done    <= w_d_done_nxt;
            d_rdata   <= w_d_rdata_nxt;
            d_err     <= w_d_err_nxt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    // A conflict is both requesters waiting while nobody owns the port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_grants       <= '0;
            d_grants        <= '0;
            conflict_cycles <= '0;
        end else begin
            if (w_grant_en && w_grant_owner == OWN_IF) if_grants <= if_grants + 1'b1;
            if (w_grant_en && w_grant_owner == OWN_D)  d_grants  <= d_grants + 1'b1;
            if (r_state == IDLE && if_req && d_req)     conflict_cycles <= conflict_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        tb_mem_init = 1'b1;
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    // DUT with MEM_LAT=1
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_done, d_done, d_err, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;

    // DUT with MEM_LAT=3
    logic        if_req_3 = 1'b0;
    logic [31:0] if_addr_3 = '0;
    logic        if_done_3, d_done_3, d_err_3, mem_en_3, mem_we_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [11:0] mem_addr_3;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] ifg_1, dg_1, cc_1, ifg_3, dg_3, cc_3;
`endif

    mem_port_arbiter #(.AW(12), .MEM_LAT(1), .MAX_STREAK(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .if_grants(ifg_1), .d_grants(dg_1), .conflict_cycles(cc_1)
`endif
    );

    mem_port_arbiter #(.AW(12), .MEM_LAT(3), .MAX_STREAK(4)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_done(if_done_3), .if_rdata(if_rdata_3),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_done(d_done_3), .d_rdata(d_rdata_3), .d_err(d_err_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3)
`ifdef MEM_ARB_STATS_EN
        , .if_grants(ifg_3), .d_grants(dg_3), .conflict_cycles(cc_3)
`endif
    );

    function automatic logic [31:0] tb_word(input int i);
        if (i == 2) return 32'h2008FFFF;
        return 32'hA5000000 | 32'(i);
    endfunction

    // Memories: data outside the valid read window is poisoned.
    logic [31:0] mem1 [0:4095];
    logic [31:0] mem3 [0:4095];
    logic [31:0] rd1, p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        if (tb_mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= tb_word(i);
                mem3[i] <= tb_word(i);
            end
        end else if (mem_en && mem_we) begin
            mem1[mem_addr] <= mem_wdata;
        end
        rd1  <= (mem_en && !mem_we) ? mem1[mem_addr] : 32'hBAD00001;
        p3_0 <= (mem_en_3 && !mem_we_3) ? mem3[mem_addr_3] : 32'hBAD00003;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rdata   = rd1;
    assign mem_rdata_3 = p3_2;

    // Transaction model of the MEM_LAT=1 instance.
    int          cyc = 0;
    logic [31:0] m_mem [0:4095];
    logic        p_vld = 1'b0, p_if = 1'b0, p_mem = 1'b0, p_we = 1'b0, p_err = 1'b0;
    int          p_issue = 0, p_done = 0, free_at = 0, streak = 0;
    logic [11:0] p_idx = '0;
    logic [31:0] p_wdata = '0, p_rdata = '0;

    always @(posedge clk) begin
        logic take_if;
        int   lat;
        cyc = cyc + 1;
        if (tb_mem_init) for (int i = 0; i < 4096; i++) m_mem[i] = tb_word(i);
        if (!reset_n) begin
            p_vld   = 1'b0;
            streak  = 0;
            free_at = cyc + 1;
        end else begin
            if (p_vld && cyc > p_done) p_vld = 1'b0;
            if (cyc >= free_at && (if_req || d_req)) begin
                take_if = if_req && (!d_req || streak == 4);
                if (take_if || !if_req) streak = 0;
                else if (streak < 4) streak = streak + 1;
                p_vld = 1'b1; p_if = take_if; p_issue = cyc;
                p_we = 1'b0; p_wdata = '0; p_err = 1'b0; p_rdata = '0; p_mem = 1'b1;
                if (take_if) begin
                    p_idx = if_addr[13:2]; p_rdata = m_mem[p_idx]; lat = 3;
                end else if (d_addr[1:0] != 2'b00) begin
                    p_mem = 1'b0; p_err = 1'b1; lat = 1;
                end else begin
                    p_idx = d_addr[13:2];
                    if (d_we) begin
                        p_we = 1'b1; p_wdata = d_wdata; m_mem[p_idx] = d_wdata; lat = 2;
                    end else begin
                        p_rdata = m_mem[p_idx]; lat = 3;
                    end
                end
                p_done  = cyc + lat - 1;
                free_at = cyc + lat + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        logic e_ifd, e_dd, e_men;
        #1;
        if (chk_en) begin
            e_ifd = p_vld && p_if && (cyc == p_done);
            e_dd  = p_vld && !p_if && (cyc == p_done);
            e_men = p_vld && p_mem && (cyc == p_issue);
            chk("cyc_if_done", if_done, e_ifd);
            chk("cyc_d_done", d_done, e_dd);
            chk("cyc_mem_en", mem_en, e_men);
            if (e_men) begin
                chk("cyc_mem_addr", mem_addr, p_idx);
                chk("cyc_mem_we", mem_we, p_we);
                chk("cyc_mem_wdata", mem_wdata, p_wdata);
            end else begin
                chk("cyc_mem_we_idle", mem_we, 1'b0);
            end
            if (e_ifd) begin
                chk("cyc_if_rdata", if_rdata, p_rdata);
                chk("cyc_d_rdata_nonowner", d_rdata, 32'h0);
            end
            if (e_dd) begin
                chk("cyc_d_rdata", d_rdata, p_rdata);
                chk("cyc_d_err", d_err, p_err);
                chk("cyc_if_rdata_nonowner", if_rdata, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the MEM_LAT=1 instance with hand-computed expectations.
    task automatic do_req(input string name, input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_k, input logic [31:0] exp_rdata,
                          input bit exp_err, input int exp_mem_cnt, input logic [11:0] exp_maddr,
                          input bit exp_mwe);
        int k = 0, mem_cnt = 0;
        bit got = 0;
        logic [11:0] maddr = '0;
        logic mwe = 1'b0;
        logic [31:0] rdata = '0;
        logic err = 1'b0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        while (!got && k < 20) begin
            tick();
            k++;
            if (mem_en) begin
                mem_cnt++; maddr = mem_addr; mwe = mem_we;
            end
            if (is_if ? if_done : d_done) begin
                got = 1; rdata = is_if ? if_rdata : d_rdata; err = d_err;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk({name, "_done_seen"}, got, 1'b1);
        chk({name, "_latency"}, k, exp_k);
        chk({name, "_rdata"}, rdata, exp_rdata);
        if (!is_if) chk({name, "_err"}, err, exp_err);
        chk({name, "_mem_en_count"}, mem_cnt, exp_mem_cnt);
        if (exp_mem_cnt == 1) begin
            chk({name, "_mem_addr"}, maddr, exp_maddr);
            chk({name, "_mem_we"}, mwe, exp_mwe);
        end
        tick();
    endtask

    initial begin
        int    n, k;
        string seq;
        bit    got;

        repeat (3) tick();
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_d_done", d_done, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_err", d_err, 1'b0);
        tb_mem_init = 1'b0;
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick();

        //      name       if we addr          wdata         k  rdata          err mem addr   we
        do_req("fetch8",   1, 0, 32'h00000008, 32'h0,        3, 32'h2008FFFF, 0,  1, 12'd2,    0);
        do_req("store",    0, 1, 32'h00002000, 32'hDEADBEEF, 2, 32'h0,        0,  1, 12'd2048, 1);
        do_req("load",     0, 0, 32'h00002000, 32'h0,        3, 32'hDEADBEEF, 0,  1, 12'd2048, 0);
        do_req("mis_st",   0, 1, 32'h00002002, 32'hFFFFFFFF, 1, 32'h0,        1,  0, 12'd0,    0);
        do_req("reload",   0, 0, 32'h00002000, 32'h0,        3, 32'hDEADBEEF, 0,  1, 12'd2048, 0);
        do_req("fetchwrap",1, 0, 32'h00004008, 32'h0,        3, 32'h2008FFFF, 0,  1, 12'd2,    0);
        do_req("st_wrap",  0, 1, 32'hFFFF2004, 32'h12345678, 2, 32'h0,        0,  1, 12'd2049, 1);
        do_req("ld_2004",  0, 0, 32'h00002004, 32'h0,        3, 32'h12345678, 0,  1, 12'd2049, 0);
        do_req("mis_ld",   0, 0, 32'h00002001, 32'h0,        1, 32'h0,        1,  0, 12'd0,    0);

        // Both requesters held continuously.
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        seq = ""; n = 0; k = 0;
        while (n < 10 && k < 200) begin
            tick();
            k++;
            if (if_done) begin seq = {seq, "I"}; n++; end
            if (d_done) begin seq = {seq, "D"}; n++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (seq != "DDDDIDDDDI") begin
            n_err++;
            $display("FAIL grant_seq: got %s, expected DDDDIDDDDI", seq);
        end
        tick();

        // Reset while a load sits in WAIT.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        tick();
        reset_n = 1'b0; d_req = 1'b0;
        tick();
        chk("midrst_d_done", d_done, 1'b0);
        chk("midrst_d_rdata", d_rdata, 32'h0);
        chk("midrst_mem_en", mem_en, 1'b0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_if_done", if_done, 1'b0);
        reset_n = 1'b1;
        got = 0;
        repeat (4) begin
            tick();
            if (d_done) got = 1;
        end
        chk("midrst_no_done", got, 1'b0);
        do_req("ld_after_rst", 0, 0, 32'h2000, 32'h0, 3, 32'hDEADBEEF, 0, 1, 12'd2048, 0);

        // Five fetches on the MEM_LAT=3 instance.
        for (int f = 0; f < 5; f++) begin
            if_req_3 = 1'b1; if_addr_3 = 32'(f * 4);
            k = 0; got = 0;
            while (!got && k < 20) begin
                tick();
                k++;
                if (if_done_3) got = 1;
            end
            if_req_3 = 1'b0;
            chk("lat3_latency", k, 5);
            chk("lat3_rdata", if_rdata_3, tb_word(f));
            tick();
        end
`ifdef MEM_ARB_STATS_EN
        chk("lat3_if_grants", ifg_3, 32'd5);
        chk("lat3_d_grants", dg_3, 32'd0);
        chk("lat3_conflicts", cc_3, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
